select_loader: RTL and testbench

- Host-facing controller that drives the design-select interface consumed by the chip's design multiplexer: des_sel, hold_if_not_sel and sync_inputs.
- Receives an 8-bit configuration frame over a slow 3-wire serial link (cfg_sclk, cfg_sdata, cfg_load) from chip pins.
- Commits each frame atomically, then issues a timed reset request so the newly selected design starts clean.
- Sits between the pad ring and the multiplexer.

---
 rtl/select_loader_pkg.sv | 23 ++
 rtl/select_loader_sync_edge.sv | 30 +++
 rtl/select_loader.sv | 159 +++++++++++++++
 tb/tb_select_loader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/select_loader_pkg.sv
// Shared types and sizes for the design-select loader.
// The select width lives here so the frame struct and the top agree on it.
package select_loader_pkg;

   localparam int SEL_W      = 6;
   localparam int FRAME_BITS = SEL_W + 2;
   // Bit counter must reach FRAME_BITS+1 so over-long frames stay distinguishable.
   localparam int CNT_W      = $clog2(FRAME_BITS + 2);

   typedef struct packed {
      logic             sync_inputs;
      logic             hold_if_not_sel;
      logic [SEL_W-1:0] des_sel;
   } cfg_frame_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT,
      RESET_HOLD
   } state_t;

endpackage

// File: rtl/select_loader_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus registered rise/fall pulses.
// level is delayed to line up with rise/fall so decisions see one consistent sample.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         chain <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         level <= chain[STAGES-1];
         rise  <= chain[STAGES-1] & ~level;
         fall  <= ~chain[STAGES-1] & level;
      end
   end

endmodule

// File: rtl/select_loader.sv
// Serial design-select loader: shifts in a frame, commits it atomically, then holds a reset pulse.
// Optional cfg_sdo readback of the committed config is enabled with SELECT_LOADER_READBACK_EN.
module select_loader
   import select_loader_pkg::*;
#(
   parameter int RST_CYCLES  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cfg_sclk,
   input  logic             cfg_sdata,
   input  logic             cfg_load,
   output logic [SEL_W-1:0] des_sel,
   output logic             hold_if_not_sel,
   output logic             sync_inputs,
   output logic             des_reset_req,
   output logic             busy,
   output logic             frame_err
`ifdef SELECT_LOADER_READBACK_EN
   ,
   output logic             cfg_sdo
`endif
);

   localparam logic [7:0]       RST_LOAD    = 8'(RST_CYCLES);
   localparam logic [7:0]       RST_LOAD_M1 = 8'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(FRAME_BITS + 1);

   logic sclk_level, sclk_rise, sclk_fall;
   logic load_level, load_rise, load_fall;
   logic unused_sclk;

   sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
      .clock (clock),
      .reset (reset),
      .din   (cfg_sclk),
      .level (sclk_level),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES)) u_load_sync (
      .clock (clock),
      .reset (reset),
      .din   (cfg_load),
      .level (load_level),
      .rise  (load_rise),
      .fall  (load_fall)
   );

   assign unused_sclk = sclk_level ^ sclk_fall;

   // Data gets one extra flop so it lines up with the registered edge pulses.
   logic [SYNC_STAGES:0] sdata_q;
   logic                 sdata_s;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) sdata_q <= '0;
      else        sdata_q <= {sdata_q[SYNC_STAGES-1:0], cfg_sdata};
   end

   assign sdata_s = sdata_q[SYNC_STAGES];

   state_t                state;
   logic [FRAME_BITS-1:0] shreg;
   logic [CNT_W-1:0]      bit_cnt;
   logic [7:0]            rst_cnt;
   cfg_frame_t            cfg_q;

`ifdef SELECT_LOADER_READBACK_EN
   logic [FRAME_BITS-1:0] rb_q;
   logic [FRAME_BITS-1:0] cfg_bits;
   assign cfg_bits = cfg_q;
`endif

   assign des_sel         = cfg_q.des_sel;
   assign hold_if_not_sel = cfg_q.hold_if_not_sel;
   assign sync_inputs     = cfg_q.sync_inputs;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= RESET_HOLD;
         shreg         <= '0;
         bit_cnt       <= '0;
         rst_cnt       <= RST_LOAD;
         cfg_q         <= '0;
         des_reset_req <= 1'b1;
         busy          <= 1'b1;
         frame_err     <= 1'b0;
`ifdef SELECT_LOADER_READBACK_EN
         rb_q          <= '0;
         cfg_sdo       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (load_rise) begin
                  shreg   <= '0;
                  bit_cnt <= '0;
                  state   <= SHIFT;
`ifdef SELECT_LOADER_READBACK_EN
                  cfg_sdo <= cfg_bits[FRAME_BITS-1];
                  rb_q    <= {cfg_bits[FRAME_BITS-2:0], 1'b0};
`endif
               end
            end
            SHIFT: begin
               // A load fall outranks an sclk rise seen in the same cycle.
               if (load_fall) begin
`ifdef SELECT_LOADER_READBACK_EN
                  cfg_sdo <= 1'b0;
`endif
                  if (bit_cnt == CNT_FULL) begin
                     cfg_q         <= cfg_frame_t'(shreg);
                     des_reset_req <= 1'b1;
                     busy          <= 1'b1;
                     frame_err     <= 1'b0;
                     state         <= COMMIT;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= IDLE;
                  end
               end else if (sclk_rise && load_level) begin
                  shreg <= {shreg[FRAME_BITS-2:0], sdata_s};
                  if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
`ifdef SELECT_LOADER_READBACK_EN
                  cfg_sdo <= rb_q[FRAME_BITS-1];
                  rb_q    <= {rb_q[FRAME_BITS-2:0], 1'b0};
`endif
               end
            end
            COMMIT: begin
               // The COMMIT cycle is the first cycle of the reset pulse.
               if (RST_CYCLES == 1) begin
                  des_reset_req <= 1'b0;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end else begin
                  rst_cnt <= RST_LOAD_M1;
                  state   <= RESET_HOLD;
               end
            end
            RESET_HOLD: begin
               if (rst_cnt <= 8'd1) begin
                  des_reset_req <= 1'b0;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end else begin
                  rst_cnt <= rst_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_select_loader.sv
// Bench for select_loader: serial frame driver, behavioural model of committed config and pulse counts.
// Readback checks are included when SELECT_LOADER_READBACK_EN is defined.
module tb_select_loader;

   localparam int RST = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       cfg_sclk = 1'b0;
   logic       cfg_sdata = 1'b0;
   logic       cfg_load = 1'b0;
   logic [5:0] des_sel;
   logic       hold_if_not_sel, sync_inputs, des_reset_req, busy, frame_err;
`ifdef SELECT_LOADER_READBACK_EN
   logic       cfg_sdo;
`endif

   select_loader dut (
      .clock           (clock),
      .reset           (reset),
      .cfg_sclk        (cfg_sclk),
      .cfg_sdata       (cfg_sdata),
      .cfg_load        (cfg_load),
      .des_sel         (des_sel),
      .hold_if_not_sel (hold_if_not_sel),
      .sync_inputs     (sync_inputs),
      .des_reset_req   (des_reset_req),
      .busy            (busy),
      .frame_err       (frame_err)
`ifdef SELECT_LOADER_READBACK_EN
      ,
      .cfg_sdo         (cfg_sdo)
`endif
   );

   always #5 clock = ~clock;

   int         n_checks = 0;
   int         n_pass = 0;
   int         n_tmo = 0;
   int         run_len = 0;
   int         last_len = 0;
   int         pulses = 0;
   logic [7:0] exp_cfg = 8'h00;
   logic       exp_err = 1'b0;
   logic [7:0] rb_bits = 8'h00;

   // Reset-request pulse monitor: length of each pulse in clock cycles and pulse count.
   always @(negedge clock) begin
      if (!reset) run_len = 0;
      else if (des_reset_req) run_len++;
      else if (run_len > 0) begin
         last_len = run_len;
         pulses++;
         run_len = 0;
      end
   end

   function automatic logic [7:0] cur_cfg();
      return {sync_inputs, hold_if_not_sel, des_sel};
   endfunction

   task automatic send_frame(input logic [7:0] val, input int nbits);
      logic [7:0] v;
      v = val;
      @(negedge clock);
      cfg_load = 1'b1;
      repeat (4) @(negedge clock);
      for (int i = 0; i < nbits; i++) begin
         cfg_sdata = v[7];
         v = v << 1;
         repeat (3) @(negedge clock);
`ifdef SELECT_LOADER_READBACK_EN
         rb_bits = {rb_bits[6:0], cfg_sdo};
`endif
         cfg_sclk = 1'b1;
         repeat (3) @(negedge clock);
         cfg_sclk = 1'b0;
      end
      repeat (3) @(negedge clock);
      cfg_load = 1'b0;
   endtask

   task automatic await_result(output int latency, output logic [7:0] seen);
      int k;
      latency = 0;
      seen = 8'h00;
      for (int i = 0; i < 12; i++) begin
         @(posedge clock);
         #1;
         latency++;
         if (des_reset_req) begin
            seen = cur_cfg();
            break;
         end
      end
      k = 0;
      while (busy && k < 40) begin
         @(negedge clock);
         k++;
      end
      if (busy) n_tmo++;
      repeat (2) @(negedge clock);
   endtask

   task automatic wait_not_busy();
      int k;
      k = 0;
      while (busy && k < 40) begin
         @(negedge clock);
         k++;
      end
      if (busy) n_tmo++;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clock);
      #1;
      n_checks++; if (cur_cfg() !== 8'h00) $display("FAIL reset_cfg got=%h exp=00", cur_cfg()); else n_pass++;
      n_checks++; if (des_reset_req !== 1'b1) $display("FAIL reset_req got=%b exp=1", des_reset_req); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy got=%b exp=1", busy); else n_pass++;
      n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", frame_err); else n_pass++;
      @(posedge clock);
      #2 reset = 1'b1;
      wait_not_busy();
      n_checks++; if (last_len !== RST) $display("FAIL reset_pulse_len got=%0d exp=%0d", last_len, RST); else n_pass++;
      n_checks++; if (pulses !== 1) $display("FAIL reset_pulse_count got=%0d exp=1", pulses); else n_pass++;
      n_checks++; if ({busy, des_reset_req} !== 2'b00) $display("FAIL reset_idle got=%b exp=00", {busy, des_reset_req}); else n_pass++;
   endtask

   task automatic test_valid_frame();
      int         lat, p0;
      logic [7:0] seen;
      p0 = pulses;
      send_frame(8'hC5, 8);
      await_result(lat, seen);
      exp_cfg = 8'hC5;
      exp_err = 1'b0;
      n_checks++; if (lat !== 4) $display("FAIL valid_latency got=%0d exp=4", lat); else n_pass++;
      n_checks++; if (seen !== exp_cfg) $display("FAIL valid_cfg_at_req got=%h exp=%h", seen, exp_cfg); else n_pass++;
      n_checks++; if (des_sel !== 6'd5) $display("FAIL valid_des_sel got=%0d exp=5", des_sel); else n_pass++;
      n_checks++; if ({sync_inputs, hold_if_not_sel} !== 2'b11) $display("FAIL valid_flags got=%b exp=11", {sync_inputs, hold_if_not_sel}); else n_pass++;
      n_checks++; if (frame_err !== exp_err) $display("FAIL valid_err got=%b exp=%b", frame_err, exp_err); else n_pass++;
      n_checks++; if (pulses !== p0 + 1 || last_len !== RST) $display("FAIL valid_pulse got=%0d/%0d exp=%0d/%0d", pulses, last_len, p0 + 1, RST); else n_pass++;
   endtask

   task automatic test_bad_lengths();
      int         lens[2] = '{7, 9};
      int         lat, p0;
      logic [7:0] seen;
      for (int j = 0; j < 2; j++) begin
         p0 = pulses;
         send_frame(8'h3F, lens[j]);
         await_result(lat, seen);
         exp_err = 1'b1;
         n_checks++; if (frame_err !== exp_err) $display("FAIL bad_len%0d_err got=%b exp=1", lens[j], frame_err); else n_pass++;
         n_checks++; if (cur_cfg() !== exp_cfg) $display("FAIL bad_len%0d_cfg got=%h exp=%h", lens[j], cur_cfg(), exp_cfg); else n_pass++;
         n_checks++; if (lat !== 12 || pulses !== p0) $display("FAIL bad_len%0d_no_pulse got=%0d/%0d exp=12/%0d", lens[j], lat, pulses, p0); else n_pass++;
      end
      send_frame(8'h02, 8);
      await_result(lat, seen);
      exp_cfg = 8'h02;
      exp_err = 1'b0;
      n_checks++; if (cur_cfg() !== exp_cfg) $display("FAIL recover_cfg got=%h exp=%h", cur_cfg(), exp_cfg); else n_pass++;
      n_checks++; if (frame_err !== exp_err) $display("FAIL recover_err got=%b exp=0", frame_err); else n_pass++;
   endtask

   task automatic test_reselect();
      int         lat, p0;
      logic [7:0] seen;
      p0 = pulses;
      send_frame(exp_cfg, 8);
      await_result(lat, seen);
      n_checks++; if (cur_cfg() !== exp_cfg) $display("FAIL reselect_cfg got=%h exp=%h", cur_cfg(), exp_cfg); else n_pass++;
      n_checks++; if (lat !== 4) $display("FAIL reselect_latency got=%0d exp=4", lat); else n_pass++;
      n_checks++; if (pulses !== p0 + 1 || last_len !== RST) $display("FAIL reselect_pulse got=%0d/%0d exp=%0d/%0d", pulses, last_len, p0 + 1, RST); else n_pass++;
   endtask

   task automatic test_busy_ignore();
      int         lat, p0;
      logic       seen_req;
      logic [7:0] seen;
      p0 = pulses;
      send_frame(8'h45, 8);
      exp_cfg = 8'h45;
      seen_req = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clock);
         #1;
         if (des_reset_req) begin
            seen_req = 1'b1;
            break;
         end
      end
      if (!seen_req) n_tmo++;
      @(negedge clock);
      cfg_load = 1'b1;
      cfg_sclk = 1'b1;
      repeat (2) @(negedge clock);
      cfg_sclk = 1'b0;
      repeat (2) @(negedge clock);
      cfg_sclk = 1'b1;
      repeat (2) @(negedge clock);
      cfg_sclk = 1'b0;
      wait_not_busy();
      repeat (6) @(negedge clock);
      cfg_sclk = 1'b1;
      repeat (3) @(negedge clock);
      cfg_sclk = 1'b0;
      repeat (10) @(negedge clock);
      n_checks++; if (cur_cfg() !== exp_cfg) $display("FAIL busy_cfg got=%h exp=%h", cur_cfg(), exp_cfg); else n_pass++;
      n_checks++; if (pulses !== p0 + 1 || last_len !== RST) $display("FAIL busy_pulse got=%0d/%0d exp=%0d/%0d", pulses, last_len, p0 + 1, RST); else n_pass++;
      cfg_load = 1'b0;
      repeat (10) @(negedge clock);
      n_checks++; if (frame_err !== 1'b0) $display("FAIL held_load_err got=%b exp=0", frame_err); else n_pass++;
      n_checks++; if (pulses !== p0 + 1) $display("FAIL held_load_pulses got=%0d exp=%0d", pulses, p0 + 1); else n_pass++;
      send_frame(8'h8A, 8);
      await_result(lat, seen);
      exp_cfg = 8'h8A;
      n_checks++; if (cur_cfg() !== exp_cfg || lat !== 4) $display("FAIL fresh_rise got=%h/%0d exp=%h/4", cur_cfg(), lat, exp_cfg); else n_pass++;
   endtask

   task automatic test_async_reset();
      int         lat;
      logic [7:0] seen;
      logic [7:0] v;
      send_frame(8'h00, 3);
      await_result(lat, seen);
      n_checks++; if (frame_err !== 1'b1) $display("FAIL pre_reset_err got=%b exp=1", frame_err); else n_pass++;
      @(negedge clock);
      cfg_load = 1'b1;
      repeat (4) @(negedge clock);
      v = 8'hA6;
      for (int i = 0; i < 4; i++) begin
         cfg_sdata = v[7];
         v = v << 1;
         repeat (3) @(negedge clock);
         cfg_sclk = 1'b1;
         repeat (3) @(negedge clock);
         cfg_sclk = 1'b0;
      end
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      n_checks++; if (cur_cfg() !== 8'h00) $display("FAIL async_cfg got=%h exp=00", cur_cfg()); else n_pass++;
      n_checks++; if ({des_reset_req, busy, frame_err} !== 3'b110) $display("FAIL async_ctrl got=%b exp=110", {des_reset_req, busy, frame_err}); else n_pass++;
      @(negedge clock);
      cfg_load = 1'b0;
      cfg_sclk = 1'b0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b1;
      wait_not_busy();
      exp_cfg = 8'h00;
      exp_err = 1'b0;
      n_checks++; if (last_len !== RST) $display("FAIL async_release_pulse got=%0d exp=%0d", last_len, RST); else n_pass++;
      send_frame(8'h01, 8);
      await_result(lat, seen);
      exp_cfg = 8'h01;
      n_checks++; if (cur_cfg() !== exp_cfg || frame_err !== 1'b0) $display("FAIL after_reset_cfg got=%h/%b exp=01/0", cur_cfg(), frame_err); else n_pass++;
      send_frame(8'h3C, 8);
      await_result(lat, seen);
      n_checks++; if (cur_cfg() !== 8'h3C) $display("FAIL next_cfg got=%h exp=3c", cur_cfg()); else n_pass++;
`ifdef SELECT_LOADER_READBACK_EN
      n_checks++; if (rb_bits !== exp_cfg) $display("FAIL readback got=%h exp=%h", rb_bits, exp_cfg); else n_pass++;
`endif
      exp_cfg = 8'h3C;
   endtask

   task automatic test_random();
      int         lat, p0, nbits;
      logic [7:0] val, prev, seen;
      for (int it = 0; it < 8; it++) begin
         nbits = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : 8;
         val = 8'($urandom_range(0, 255));
         prev = exp_cfg;
         p0 = pulses;
         send_frame(val, nbits);
         await_result(lat, seen);
         if (nbits == 8) begin
            exp_cfg = val;
            exp_err = 1'b0;
         end else begin
            exp_err = 1'b1;
         end
         n_checks++; if (cur_cfg() !== exp_cfg) $display("FAIL rand%0d_cfg n=%0d got=%h exp=%h", it, nbits, cur_cfg(), exp_cfg); else n_pass++;
         n_checks++; if (frame_err !== exp_err) $display("FAIL rand%0d_err n=%0d got=%b exp=%b", it, nbits, frame_err, exp_err); else n_pass++;
         n_checks++; if (pulses !== p0 + ((nbits == 8) ? 1 : 0)) $display("FAIL rand%0d_pulses n=%0d got=%0d exp=%0d", it, nbits, pulses, p0 + ((nbits == 8) ? 1 : 0)); else n_pass++;
`ifdef SELECT_LOADER_READBACK_EN
         if (nbits == 8) begin
            n_checks++; if (rb_bits !== prev) $display("FAIL rand%0d_readback got=%h exp=%h", it, rb_bits, prev); else n_pass++;
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_valid_frame();
      test_bad_lengths();
      test_reselect();
      test_busy_ignore();
      test_async_reset();
      test_random();
      n_checks++; if (n_tmo !== 0) $display("FAIL wait_bounds got=%0d timeouts exp=0", n_tmo); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
